axil_protocol_monitor: RTL and testbench

Synthesizable AXI4-Lite protocol monitor for one master/slave link; the RTL successor to the SVA-only checker set. It checks handshake stability, VALID-stall timeouts and outstanding-transaction accounting on all five channels, then reports violations as sticky status bits, a one-cycle pulse and a first-error code. It attaches passively, input-only on the bus, beside any AXI-Lite slave, and is readable by software or a debug core.

---
 rtl/axil_mon_pkg.sv | 31 +++
 rtl/axil_mon_chan.sv | 45 ++++
 rtl/axil_protocol_monitor.sv | 115 +++++++++++
 tb/tb_axil_protocol_monitor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/axil_mon_pkg.sv
// Shared definitions for the AXI4-Lite protocol monitor: error indices,
// the first-error code type and a lowest-set-bit helper.
package axil_mon_pkg;
  localparam int ERR_W  = 14;
  localparam int NUM_CH = 5;

  typedef enum logic [3:0] {
    AR_STABLE    = 4'd0,
    AW_STABLE    = 4'd1,
    W_STABLE     = 4'd2,
    R_STABLE     = 4'd3,
    B_STABLE     = 4'd4,
    AR_TIMEOUT   = 4'd5,
    AW_TIMEOUT   = 4'd6,
    W_TIMEOUT    = 4'd7,
    R_TIMEOUT    = 4'd8,
    B_TIMEOUT    = 4'd9,
    R_UNEXPECTED = 4'd10,
    B_UNEXPECTED = 4'd11,
    RD_OVERFLOW  = 4'd12,
    WR_OVERFLOW  = 4'd13
  } err_idx_e;

  typedef logic [3:0] err_code_t;

  function automatic err_code_t lowest_err(input logic [ERR_W-1:0] v);
    lowest_err = '0;
    for (int i = ERR_W-1; i >= 0; i--)
      if (v[i]) lowest_err = err_code_t'(i);
  endfunction
endpackage

// File: rtl/axil_mon_chan.sv
// One VALID/READY channel watcher: payload/VALID stability against the
// previous stalled cycle, stall counter with a single-shot timeout, handshake strobe.
module axil_mon_chan #(
  parameter int PW       = 32,
  parameter int MAX_WAIT = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          ready,
  input  logic [PW-1:0] payload,
  output logic          hs,
  output logic          stable_err,
  output logic          timeout_err
);
  localparam int WW = $clog2(MAX_WAIT+2);
  localparam logic [WW-1:0] W_FIRE = WW'(MAX_WAIT);
  localparam logic [WW-1:0] W_SAT  = WW'(MAX_WAIT+1);

  logic          prev_vld, prev_rdy;
  logic [PW-1:0] prev_pay;
  logic [WW-1:0] wait_cnt;
  logic          stall;

  assign stall       = valid & ~ready;
  assign hs          = valid & ready;
  assign stable_err  = prev_vld & ~prev_rdy & (~valid | (payload != prev_pay));
  // Saturating one past the fire point keeps a long stall from re-firing.
  assign timeout_err = stall & (wait_cnt == W_FIRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vld <= 1'b0;
      prev_rdy <= 1'b0;
      prev_pay <= '0;
      wait_cnt <= '0;
    end else begin
      prev_vld <= valid;
      prev_rdy <= ready;
      prev_pay <= payload;
      if (!stall)                wait_cnt <= '0;
      else if (wait_cnt != W_SAT) wait_cnt <= wait_cnt + WW'(1);
    end
  end
endmodule

// File: rtl/axil_protocol_monitor.sv
// Passive AXI4-Lite link monitor: per-channel checks plus outstanding
// read/write accounting, reported as sticky bits, a pulse and a first-error code.
module axil_protocol_monitor
  import axil_mon_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int MAX_WAIT         = 5,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESET,
  input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
  input  logic                        AXI_ARVALID,
  input  logic                        AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
  input  logic                        AXI_RVALID,
  input  logic                        AXI_RREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR,
  input  logic                        AXI_AWVALID,
  input  logic                        AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA,
  input  logic                        AXI_WVALID,
  input  logic                        AXI_WREADY,
  input  logic [1:0]                  AXI_BRESP,
  input  logic                        AXI_BVALID,
  input  logic                        AXI_BREADY,
  input  logic                        err_clear,
  output logic [ERR_W-1:0]            err_sticky,
  output logic                        err_pulse,
  output logic                        first_err_vld,
  output logic [3:0]                  first_err_code,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int PW    = (C_AXI_DATA_WIDTH > C_AXI_ADDR_WIDTH) ? C_AXI_DATA_WIDTH : C_AXI_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // Channel order AR, AW, W, R, B matches the STABLE/TIMEOUT index order.
  logic [NUM_CH-1:0]         ch_vld, ch_rdy, ch_hs, stab, tout;
  logic [NUM_CH-1:0][PW-1:0] ch_pay;

  assign ch_vld = {AXI_BVALID, AXI_RVALID, AXI_WVALID, AXI_WVALID & 1'b0 | AXI_AWVALID, AXI_ARVALID};
  assign ch_rdy = {AXI_BREADY, AXI_RREADY, AXI_WREADY, AXI_AWREADY, AXI_ARREADY};
  assign ch_pay[0] = PW'(AXI_ARADDR);
  assign ch_pay[1] = PW'(AXI_AWADDR);
  assign ch_pay[2] = PW'(AXI_WDATA);
  assign ch_pay[3] = PW'(AXI_RDATA);
  assign ch_pay[4] = PW'(AXI_BRESP);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    axil_mon_chan #(.PW(PW), .MAX_WAIT(MAX_WAIT)) u_chan (
      .clk(AXI_ACLK), .rst(AXI_ARESET),
      .valid(ch_vld[c]), .ready(ch_rdy[c]), .payload(ch_pay[c]),
      .hs(ch_hs[c]), .stable_err(stab[c]), .timeout_err(tout[c])
    );
  end

  logic [CNT_W-1:0] aw_pend, w_pend;
  logic             ar_hs, aw_hs, w_hs, r_hs, b_hs, b_ok;
  logic             r_unexp, rd_ovf, b_unexp, wr_ovf;
  logic [ERR_W-1:0] viol;

  assign ar_hs = ch_hs[0];
  assign aw_hs = ch_hs[1];
  assign w_hs  = ch_hs[2];
  assign r_hs  = ch_hs[3];
  assign b_hs  = ch_hs[4];

  // B only retires a write whose AW and W both completed in earlier cycles.
  assign b_ok    = b_hs & (aw_pend != '0) & (w_pend != '0);
  assign b_unexp = b_hs & ~b_ok;
  assign r_unexp = r_hs & (rd_outstanding == '0);
  assign rd_ovf  = ar_hs & ~r_hs & (rd_outstanding == MAX_CNT);
  assign wr_ovf  = ~b_hs & ((aw_hs & (aw_pend == MAX_CNT)) | (w_hs & (w_pend == MAX_CNT)));

  always_comb begin
    viol                = {wr_ovf, rd_ovf, b_unexp, 1'b0, tout, stab};
    viol[R_UNEXPECTED]  = r_unexp;
  end

  // Increment saturates at MAX_CNT; a simultaneous inc/dec leaves the count alone.
  function automatic logic [CNT_W-1:0] pend_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    if (dec && !inc)                    pend_next = cnt - CNT_W'(1);
    else if (inc && !dec && cnt != MAX_CNT) pend_next = cnt + CNT_W'(1);
    else                                pend_next = cnt;
  endfunction

  assign wr_outstanding = (aw_pend > w_pend) ? aw_pend : w_pend;

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      rd_outstanding <= '0;
      aw_pend        <= '0;
      w_pend         <= '0;
      err_sticky     <= '0;
      err_pulse      <= 1'b0;
      first_err_vld  <= 1'b0;
      first_err_code <= '0;
    end else begin
      rd_outstanding <= pend_next(rd_outstanding, ar_hs, r_hs & ~r_unexp);
      aw_pend        <= pend_next(aw_pend, aw_hs, b_ok);
      w_pend         <= pend_next(w_pend, w_hs, b_ok);
      err_pulse      <= |viol;
      err_sticky     <= (err_clear ? '0 : err_sticky) | viol;
      // Clear re-arms capture in the same cycle, so a coincident violation is kept.
      if (err_clear || !first_err_vld) begin
        first_err_vld  <= |viol;
        first_err_code <= lowest_err(viol);
      end
    end
  end
endmodule

// File: tb/tb_axil_protocol_monitor.sv
// Bench for axil_protocol_monitor: hand-computed vector table for the corner
// sequences, then random bus traffic checked against a cycle-level reference model.
module tb_axil_protocol_monitor;
  localparam int MAX_WAIT = 5;
  localparam int MAX_OUT  = 4;

  localparam logic [9:0] C_ARV = 10'h200, C_ARR = 10'h100, C_AWV = 10'h080, C_AWR = 10'h040,
                         C_WV  = 10'h020, C_WR  = 10'h010, C_RV  = 10'h008, C_RR  = 10'h004,
                         C_BV  = 10'h002, C_BR  = 10'h001;

  typedef struct packed {
    logic arv, arr; logic [7:0] araddr;
    logic rv, rr;   logic [31:0] rdata;
    logic awv, awr; logic [7:0] awaddr;
    logic wv, wr;   logic [31:0] wdata;
    logic bv, br;   logic [1:0] bresp;
  } bus_t;

  typedef struct packed {
    logic [9:0]  ctl;
    logic [7:0]  awaddr;
    logic        clr, rst;
    logic [13:0] sticky;
    logic        pulse, fvld;
    logic [3:0]  code;
    logic [2:0]  rd, wr;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b0, err_clear = 1'b0;
  logic [7:0]  araddr = '0, awaddr = '0;
  logic [31:0] rdata = '0, wdata = '0;
  logic [1:0]  bresp = '0;
  logic arv = 0, arr = 0, rv = 0, rr = 0, awv = 0, awr = 0, wv = 0, wr = 0, bv = 0, br = 0;
  logic [13:0] err_sticky;
  logic        err_pulse, first_err_vld;
  logic [3:0]  first_err_code;
  logic [2:0]  rd_outstanding, wr_outstanding;

  always #5 clk = ~clk;

  axil_protocol_monitor #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8),
                          .MAX_WAIT(MAX_WAIT), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .AXI_ARADDR(araddr), .AXI_ARVALID(arv), .AXI_ARREADY(arr),
    .AXI_RDATA(rdata), .AXI_RVALID(rv), .AXI_RREADY(rr),
    .AXI_AWADDR(awaddr), .AXI_AWVALID(awv), .AXI_AWREADY(awr),
    .AXI_WDATA(wdata), .AXI_WVALID(wv), .AXI_WREADY(wr),
    .AXI_BRESP(bresp), .AXI_BVALID(bv), .AXI_BREADY(br),
    .err_clear(err_clear), .err_sticky(err_sticky), .err_pulse(err_pulse),
    .first_err_vld(first_err_vld), .first_err_code(first_err_code),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: counts of consecutive stall cycles and of in-flight
  // transactions, kept as plain integers.
  bit          pv[5], prd[5];
  logic [31:0] pp[5];
  int          stall[5];
  int          m_rd, m_aw, m_w, m_code;
  bit [13:0]   m_sticky;
  bit          m_pulse, m_fvld;

  function automatic int first_set(input bit [13:0] v);
    for (int i = 0; i < 14; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model(input bus_t b, input bit clr, input bit rs);
    bit v[5], r[5];
    logic [31:0] p[5];
    bit [13:0] viol;
    bit ar_h, r_h, aw_h, w_h, b_h, ok;
    int na, nw;
    v = '{b.arv, b.awv, b.wv, b.rv, b.bv};
    r = '{b.arr, b.awr, b.wr, b.rr, b.br};
    p = '{32'(b.araddr), 32'(b.awaddr), b.wdata, b.rdata, 32'(b.bresp)};
    if (rs) begin
      m_sticky = '0; m_pulse = 0; m_fvld = 0; m_code = 0; m_rd = 0; m_aw = 0; m_w = 0;
      for (int c = 0; c < 5; c++) begin pv[c] = 0; prd[c] = 0; pp[c] = '0; stall[c] = 0; end
      return;
    end
    viol = '0;
    for (int c = 0; c < 5; c++) begin
      if (pv[c] && !prd[c] && (!v[c] || p[c] != pp[c])) viol[c] = 1;
      if (v[c] && !r[c]) begin
        stall[c]++;
        if (stall[c] == MAX_WAIT + 1) viol[5+c] = 1;
      end else stall[c] = 0;
      pv[c] = v[c]; prd[c] = r[c]; pp[c] = p[c];
    end
    ar_h = b.arv & b.arr; r_h = b.rv & b.rr;
    if (r_h && m_rd == 0) begin
      viol[10] = 1;
      if (ar_h) m_rd = 1;
    end else if (ar_h && !r_h) begin
      if (m_rd == MAX_OUT) viol[12] = 1; else m_rd++;
    end else if (r_h && !ar_h) m_rd--;
    aw_h = b.awv & b.awr; w_h = b.wv & b.wr; b_h = b.bv & b.br;
    ok = b_h && m_aw > 0 && m_w > 0;
    na = m_aw; nw = m_w;
    if (b_h && !ok) viol[11] = 1;
    if (ok) begin na--; nw--; end
    if (aw_h) begin
      if (m_aw == MAX_OUT && !b_h) viol[13] = 1;
      else if (na < MAX_OUT) na++;
    end
    if (w_h) begin
      if (m_w == MAX_OUT && !b_h) viol[13] = 1;
      else if (nw < MAX_OUT) nw++;
    end
    m_aw = na; m_w = nw;
    m_sticky = (clr ? 14'h0 : m_sticky) | viol;
    m_pulse  = |viol;
    if (clr || (!m_fvld && |viol)) begin
      m_fvld = |viol;
      m_code = first_set(viol);
    end
  endtask

  task automatic step(input bus_t b, input bit clr, input bit rs);
    arv = b.arv; arr = b.arr; araddr = b.araddr;
    rv = b.rv; rr = b.rr; rdata = b.rdata;
    awv = b.awv; awr = b.awr; awaddr = b.awaddr;
    wv = b.wv; wr = b.wr; wdata = b.wdata;
    bv = b.bv; br = b.br; bresp = b.bresp;
    err_clear = clr; rst = rs;
    @(posedge clk);
    model(b, clr, rs);
    #1;
    chk("model sticky", 32'(err_sticky), 32'(m_sticky));
    chk("model pulse", 32'(err_pulse), 32'(m_pulse));
    chk("model first_vld", 32'(first_err_vld), 32'(m_fvld));
    chk("model first_code", 32'(first_err_code), 32'(m_code));
    chk("model rd_out", 32'(rd_outstanding), 32'(m_rd));
    chk("model wr_out", 32'(wr_outstanding), 32'((m_aw > m_w) ? m_aw : m_w));
  endtask

  vec_t vq[$];

  task automatic add(input logic [9:0] ctl, input logic [7:0] aw, input logic clr, input logic rs,
                     input logic [13:0] st, input logic pl, input logic fv, input logic [3:0] cd,
                     input int rdc, input int wrc);
    vq.push_back('{ctl, aw, clr, rs, st, pl, fv, cd, 3'(rdc), 3'(wrc)});
  endtask

  function automatic bus_t vec_bus(input vec_t v);
    bus_t b = '0;
    {b.arv, b.arr, b.awv, b.awr, b.wv, b.wr, b.rv, b.rr, b.bv, b.br} = v.ctl;
    b.awaddr = v.awaddr;
    return b;
  endfunction

  initial begin
    bus_t b, prev;
    // Columns: ctl, awaddr, clr, rst | sticky, pulse, first_vld, first_code, rd, wr
    add(10'h0, 8'h00, 0, 1, 14'h0000, 0, 0, 4'd0, 0, 0);
    add(10'h0, 8'h00, 0, 0, 14'h0000, 0, 0, 4'd0, 0, 0);
    add(C_AWV, 8'h10, 0, 0, 14'h0000, 0, 0, 4'd0, 0, 0);
    add(C_AWV, 8'h14, 0, 0, 14'h0002, 1, 1, 4'd1, 0, 0);
    add(C_AWV | C_AWR, 8'h14, 0, 0, 14'h0002, 0, 1, 4'd1, 0, 1);
    add(C_BV | C_BR, 8'h00, 0, 0, 14'h0802, 1, 1, 4'd1, 0, 1);
    add(C_WV | C_WR, 8'h00, 0, 0, 14'h0802, 0, 1, 4'd1, 0, 1);
    add(C_BV | C_BR, 8'h00, 0, 0, 14'h0802, 0, 1, 4'd1, 0, 0);
    add(10'h0, 8'h00, 1, 0, 14'h0000, 0, 0, 4'd0, 0, 0);
    add(C_RV | C_RR | C_BV | C_BR, 8'h00, 0, 0, 14'h0C00, 1, 1, 4'd10, 0, 0);
    add(10'h0, 8'h00, 0, 0, 14'h0C00, 0, 1, 4'd10, 0, 0);
    for (int i = 0; i < 5; i++) add(C_WV, 8'h00, 0, 0, 14'h0C00, 0, 1, 4'd10, 0, 0);
    add(C_WV, 8'h00, 0, 0, 14'h0C80, 1, 1, 4'd10, 0, 0);
    add(C_WV | C_WR, 8'h00, 0, 0, 14'h0C80, 0, 1, 4'd10, 0, 1);
    add(C_BV | C_BR, 8'h00, 1, 0, 14'h0800, 1, 1, 4'd11, 0, 1);
    add(10'h0, 8'h00, 1, 0, 14'h0000, 0, 0, 4'd0, 0, 1);
    for (int i = 1; i <= 4; i++) add(C_ARV | C_ARR, 8'h00, 0, 0, 14'h0000, 0, 0, 4'd0, i, 1);
    add(C_ARV | C_ARR, 8'h00, 0, 0, 14'h1000, 1, 1, 4'd12, 4, 1);
    for (int i = 1; i <= 4; i++) add(C_RV | C_RR, 8'h00, 0, 0, 14'h1000, 0, 1, 4'd12, 4 - i, 1);
    for (int i = 0; i < 5; i++) add(C_ARV, 8'h00, 0, 0, 14'h1000, 0, 1, 4'd12, 0, 1);
    add(C_ARV | C_ARR, 8'h00, 0, 0, 14'h1000, 0, 1, 4'd12, 1, 1);
    for (int i = 0; i < 5; i++) add(C_ARV, 8'h00, 0, 0, 14'h1000, 0, 1, 4'd12, 1, 1);
    add(C_ARV, 8'h00, 0, 0, 14'h1020, 1, 1, 4'd12, 1, 1);
    add(C_ARV | C_ARR, 8'h00, 0, 0, 14'h1020, 0, 1, 4'd12, 2, 1);
    for (int i = 0; i < 2; i++) add(C_ARV, 8'h00, 0, 0, 14'h1020, 0, 1, 4'd12, 2, 1);
    add(C_ARV, 8'h00, 0, 1, 14'h0000, 0, 0, 4'd0, 0, 0);
    add(10'h0, 8'h00, 0, 0, 14'h0000, 0, 0, 4'd0, 0, 0);

    foreach (vq[i]) begin
      step(vec_bus(vq[i]), vq[i].clr, vq[i].rst);
      chk($sformatf("row%0d sticky", i), 32'(err_sticky), 32'(vq[i].sticky));
      chk($sformatf("row%0d pulse", i), 32'(err_pulse), 32'(vq[i].pulse));
      chk($sformatf("row%0d first_vld", i), 32'(first_err_vld), 32'(vq[i].fvld));
      chk($sformatf("row%0d first_code", i), 32'(first_err_code), 32'(vq[i].code));
      chk($sformatf("row%0d rd_out", i), 32'(rd_outstanding), 32'(vq[i].rd));
      chk($sformatf("row%0d wr_out", i), 32'(wr_outstanding), 32'(vq[i].wr));
    end

    // Random traffic biased towards stalls with mostly stable payloads.
    prev = '0;
    for (int n = 0; n < 2000; n++) begin
      b = prev;
      b.arv = ($urandom_range(0, 3) != 0); b.arr = ($urandom_range(0, 2) == 0);
      b.awv = ($urandom_range(0, 3) != 0); b.awr = ($urandom_range(0, 2) == 0);
      b.wv  = ($urandom_range(0, 3) != 0); b.wr  = ($urandom_range(0, 2) == 0);
      b.rv  = ($urandom_range(0, 3) != 0); b.rr  = ($urandom_range(0, 2) == 0);
      b.bv  = ($urandom_range(0, 3) != 0); b.br  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) b.araddr = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) b.awaddr = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) b.wdata  = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) b.rdata  = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) b.bresp  = 2'($urandom_range(0, 3));
      step(b, ($urandom_range(0, 15) == 0), ($urandom_range(0, 255) == 0));
      prev = b;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
